bcd_dn_cnt_fsm: RTL and testbench
=================================

// Module: bcd_dn_cnt_fsm
// PURPOSE
//   Loadable, cascaded-digit BCD down counter built as an explicit FSM; the
//   count-down counterpart of the team's mod-10 up counter. Loaded from a
//   preset, it counts to 00, then flags terminal count. It serves as the
//   countdown/timeout timer in lab designs and drives the 7-segment display
//   path digit-for-digit.
// PARAMETERS
//   DIGITS       2   number of BCD digits; Q and din are 4*DIGITS bits wide
//   AUTO_RELOAD  0   1: an en pulse in DONE reloads the last preset and resumes
// PORTS
//   clk    in   1         rising-edge clock
//   rst_n  in   1         asynchronous active-low reset
//   load   in   1         load din into the counter (priority over en)
//   din    in   4*DIGITS  BCD preset; digit 0 is in bits [3:0]
//   en     in   1         count enable; one decrement per clk with en=1
//   Q      out  4*DIGITS  current BCD count, registered
//   zero   out  1         Q == 0, decoded from the Q register
//   busy   out  1         state == RUN
//   tc     out  1         registered one-cycle pulse on the RUN->DONE step
// BEHAVIOUR
//   One clock, one async active-low reset. All state and Q are registered.
//   Reset (async): state=IDLE, Q=0, preset register=0, tc=0; so zero=1, busy=0.
//   States and transitions (evaluated at the clk edge):
//     IDLE: load & din!=0 -> RUN;  load & din==0 -> DONE;  else stay
//     RUN : load -> reload (RUN/DONE by din as above); en & Q==1 -> DONE,
//           Q=0, tc=1; en & Q>1 -> stay, Q=Q-1 (BCD); !en -> hold
//     DONE: load -> as IDLE; en & AUTO_RELOAD & preset!=0 -> RUN, Q=preset;
//           otherwise hold with Q=0
//   Illegal state encodings fall to IDLE on the next edge.
//   BCD decrement: a digit equal to 0 with borrow_in becomes 9 and asserts
//     borrow_out; other digits decrement by 1. Q==0 never decrements, and no
//     wrap to 99..9 occurs.
//   Load: each din digit >9 saturates to 9 before it reaches Q and the preset
//     register. Load does not produce a tc pulse, not even when din==0.
//   Simultaneous load & en: load wins, with no decrement that cycle.
//   tc is high only in the cycle after the edge where Q steps from 1 to 0.
//     In every other cycle it is 0, and an AUTO_RELOAD restart drops it.
//   Latency: Q, busy and tc follow the causing edge by 0 cycles (the registered
//     value is visible immediately after that edge). zero follows Q
//     combinationally.
//   Reset mid-count: immediate return to reset values; the preset is lost.
// STRUCTURE
//   Shared package: state localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//     BCD_MAX=4'd9; a function bcd_sat(digit) that clamps to 9.
//   Sub-module bcd_digit_dn: one 4-bit digit register with ports clk, rst_n,
//     ld, d, dec, borrow_in, q, borrow_out. The top level instantiates DIGITS
//     of them in a generate chain: digit 0 takes borrow_in = (state==RUN & en &
//     Q!=0); each higher digit takes the previous borrow_out. The top level
//     owns the control FSM, the preset register, tc and zero.
// TESTING
//   1 Reset: hold rst_n=0 for 3 clk -> Q=8'h00, zero=1, busy=0, tc=0; release
//     with no load -> stays IDLE.
//   2 Load 8'h25, en=1 continuous -> Q steps 24,23,..,20,19,..,01,00. After the
//     25th enabled edge: state DONE, tc=1 for exactly 1 cycle, busy=0, and
//     Q holds 00 under further en.
//   3 Load 8'h30, toggle en 1/0 -> Q changes only on en=1 edges; the 30->29
//     borrow is correct; tc appears after 30 enabled edges.
//   4 At Q=8'h12: assert load=1, en=1, din=8'h47 -> next Q=8'h47, no decrement
//     that cycle; din=8'hA3 -> Q=8'h93; din=8'h00 -> DONE with tc=0.
//   5 AUTO_RELOAD=1, load 8'h03 -> count to 00, tc pulse; next en -> Q=8'h03,
//     busy=1; the cycle repeats indefinitely with tc every 4th enabled edge.
//   6 Load 8'h50, count to 8'h41, pulse rst_n low between clk edges -> Q=0
//     asynchronously; after release, en alone does not count (IDLE).

Source files
------------

// File: rtl/bcd_dn_cnt_fsm_pkg.sv
// Shared definitions for the cascaded-digit BCD down counter.
package bcd_dn_cnt_fsm_pkg;

    // Control FSM states; encoding 2'd3 is illegal and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp one BCD digit so non-decimal codes never reach the counter.
    function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_dn_cnt_fsm_digit.sv
// One BCD digit of the down counter: loadable, decrements on borrow_in and
// ripples a borrow to the next digit when it underflows from 0 to 9.
module bcd_digit_dn
    import bcd_dn_cnt_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld,
    input  logic [3:0] d,
    input  logic       dec,
    input  logic       borrow_in,
    output logic [3:0] q,
    output logic       borrow_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next digit value: load has priority, otherwise decrement with BCD wrap.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = d;
        end else if (dec && borrow_in) begin
            q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign borrow_out = borrow_in && (q_q == 4'd0);

endmodule

// File: rtl/bcd_dn_cnt_fsm.sv
// Loadable cascaded-digit BCD down counter with terminal-count pulse.
// The FSM, preset register and tc live here; the digits are a borrow chain.
module bcd_dn_cnt_fsm
    import bcd_dn_cnt_fsm_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    input  logic                en,
    output logic [4*DIGITS-1:0] Q,
    output logic                zero,
    output logic                busy,
    output logic                tc
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [W-1:0]   preset_q, preset_d;
    logic           tc_q, tc_d;

    logic [W-1:0]   din_sat;
    logic [W-1:0]   q_w;
    logic [W-1:0]   ld_val;
    logic [DIGITS:0] borrow_chain;
    logic           unused_borrow_msd;
    logic           q_is_zero;
    logic           q_is_one;
    logic           reload;
    logic           digit_ld;

    // Saturate every preset digit to 9 before it reaches Q or the preset.
    always_comb begin
        din_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            din_sat[4*i +: 4] = bcd_sat(din[4*i +: 4]);
        end
    end

    // Count decode, auto-reload request and digit load control.
    always_comb begin
        q_is_zero       = (q_w == '0);
        q_is_one        = (q_w == ONE);
        reload          = AUTO_RELOAD && (state_q == DONE) && en && !load
                          && (preset_q != '0);
        digit_ld        = load || reload;
        ld_val          = load ? din_sat : preset_q;
        borrow_chain[0] = (state_q == RUN) && en && !q_is_zero;
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_dn u_digit (
                .clk        (clk),
                .rst_n      (rst_n),
                .ld         (digit_ld),
                .d          (ld_val[4*g +: 4]),
                .dec        (!load),
                .borrow_in  (borrow_chain[g]),
                .q          (q_w[4*g +: 4]),
                .borrow_out (borrow_chain[g+1])
            );
        end
    endgenerate

    // A borrow out of the top digit cannot occur because Q==0 never decrements.
    assign unused_borrow_msd = borrow_chain[DIGITS];

    // Next-state, preset and terminal-count logic.
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        tc_d     = 1'b0;
        if (load) begin
            preset_d = din_sat;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = (din_sat != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (load) begin
                    state_d = (din_sat != '0) ? RUN : DONE;
                end else if (en && q_is_one) begin
                    state_d = DONE;
                    tc_d    = 1'b1;
                end
            end
            DONE: begin
                if (load) begin
                    state_d = (din_sat != '0) ? RUN : DONE;
                end else if (reload) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control FSM registers with registered tc output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            preset_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            tc_q     <= tc_d;
        end
    end

    assign Q    = q_w;
    assign zero = q_is_zero;
    assign busy = (state_q == RUN);
    assign tc   = tc_q;

endmodule

// File: tb/tb_bcd_dn_cnt_fsm.sv
// Directed bench for bcd_dn_cnt_fsm: one instance without and one with
// auto-reload, checked one cycle at a time against hand-computed values.
module tb_bcd_dn_cnt_fsm;

    logic       clk;
    logic       rst_n;
    logic       load, en;
    logic [7:0] din;
    logic [7:0] q;
    logic       zero, busy, tc;
    logic       load2, en2;
    logic [7:0] din2;
    logic [7:0] q2;
    logic       zero2, busy2, tc2;

    int checks;
    int errors;
    int cnt;

    localparam logic [7:0] AR_SEQ [4] = '{8'h02, 8'h01, 8'h00, 8'h03};

    bcd_dn_cnt_fsm #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .en(en),
        .Q(q), .zero(zero), .busy(busy), .tc(tc)
    );

    bcd_dn_cnt_fsm #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rst_n(rst_n), .load(load2), .din(din2), .en(en2),
        .Q(q2), .zero(zero2), .busy(busy2), .tc(tc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        load = 1'b0; en = 1'b0; din = 8'h00;
        load2 = 1'b0; en2 = 1'b0; din2 = 8'h00;

        // 1: reset values, then idle with no load
        repeat (3) @(posedge clk);
        #1;
        chk8("rst_q", q, 8'h00);
        chk1("rst_zero", zero, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_tc", tc, 1'b0);
        chk8("rst_q_ar", q2, 8'h00);
        rst_n = 1'b1;
        step();
        step();
        chk8("idle_q", q, 8'h00);
        chk1("idle_busy", busy, 1'b0);

        // 2: load 25 with continuous enable, count to 00
        load = 1'b1; din = 8'h25; en = 1'b1;
        step();
        chk8("ld25_q", q, 8'h25);
        chk1("ld25_busy", busy, 1'b1);
        chk1("ld25_tc", tc, 1'b0);
        load = 1'b0;
        for (int n = 24; n >= 0; n--) begin
            step();
            chk8("cnt25_q", q, to_bcd(n));
            chk1("cnt25_tc", tc, n == 0);
            chk1("cnt25_busy", busy, n != 0);
        end
        chk1("cnt25_zero", zero, 1'b1);
        step();
        chk8("done_hold_q", q, 8'h00);
        chk1("done_tc_drop", tc, 1'b0);
        chk1("done_busy", busy, 1'b0);

        // 3: load 30, enable on alternate edges
        load = 1'b1; din = 8'h30; en = 1'b0;
        step();
        chk8("ld30_q", q, 8'h30);
        load = 1'b0;
        cnt = 30;
        for (int k = 0; k < 60; k++) begin
            en = (k % 2 == 0);
            step();
            if (en) cnt--;
            chk8("cnt30_q", q, to_bcd(cnt));
            chk1("cnt30_tc", tc, en && (cnt == 0));
        end
        chk1("cnt30_busy", busy, 1'b0);

        // 4: load wins over en; saturation; zero preset goes straight to DONE
        load = 1'b1; din = 8'h12; en = 1'b0;
        step();
        chk8("ld12_q", q, 8'h12);
        din = 8'h47; en = 1'b1;
        step();
        chk8("ld47_q", q, 8'h47);
        chk1("ld47_busy", busy, 1'b1);
        chk1("ld47_tc", tc, 1'b0);
        din = 8'hA3;
        step();
        chk8("ldA3_sat_q", q, 8'h93);
        din = 8'h00;
        step();
        chk8("ld00_q", q, 8'h00);
        chk1("ld00_busy", busy, 1'b0);
        chk1("ld00_tc", tc, 1'b0);
        chk1("ld00_zero", zero, 1'b1);
        load = 1'b0; en = 1'b1;
        step();
        chk8("noar_hold_q", q, 8'h00);
        chk1("noar_tc", tc, 1'b0);
        chk1("noar_busy", busy, 1'b0);
        en = 1'b0;

        // 5: auto-reload instance cycles 03,02,01,00,03...
        load2 = 1'b1; din2 = 8'h03; en2 = 1'b1;
        step();
        chk8("ar_ld_q", q2, 8'h03);
        load2 = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 4; j++) begin
                step();
                chk8("ar_q", q2, AR_SEQ[j]);
                chk1("ar_tc", tc2, j == 2);
                chk1("ar_busy", busy2, j != 2);
            end
        end
        en2 = 1'b0;

        // 6: asynchronous reset in mid-count
        load = 1'b1; din = 8'h50; en = 1'b1;
        step();
        load = 1'b0;
        repeat (9) step();
        chk8("cnt50_q", q, 8'h41);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk8("arst_q", q, 8'h00);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_zero", zero, 1'b1);
        #2 rst_n = 1'b1;
        en = 1'b1;
        step();
        step();
        chk8("post_rst_q", q, 8'h00);
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_tc", tc, 1'b0);
        en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
